// File: rtl/uart_pkg.sv
// Shared UART transmit types: parity encodings, FSM states, latched frame config.
package uart_pkg;

    // Parity selection encodings; only odd/even put a parity bit in the frame.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_OFF  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Per-frame configuration captured at accept.
    typedef struct packed {
        logic [1:0] ptype;
        logic       stop2;
    } tx_cfg_t;

    // True when the parity encoding inserts a parity bit into the frame.
    function automatic logic has_parity(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Baud counter: counts clk cycles within one serial bit (or two for a double stop).
module tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic two_bits,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(2 * CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] term_c;

    // Terminal count for the current bit period; bit_end flags its last cycle.
    always_comb begin
        term_c  = two_bits ? CNT_W'(2 * CLKS_PER_BIT - 1) : CNT_W'(CLKS_PER_BIT - 1);
        bit_end = (cnt_q == term_c);
    end

    // Next count: restart on clear, saturate at terminal rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != term_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_frame_serializer.sv
// Serializes one frame: start bit, WIDTH data bits LSB first, optional parity, 1 or 2 stops.
module tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       parity_type,
    input  logic             stop2,
    output logic [WIDTH-1:0] data_hold,
    output logic [1:0]       type_hold,
    input  logic             parity_in,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] data_hold_q, data_hold_d;
    tx_cfg_t          cfg_q, cfg_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             accept_c;
    logic             bit_end_c;
    logic             timer_clear_c;
    logic             two_bits_c;

    // Timer restarts at every bit boundary and is parked at zero while idle.
    always_comb begin
        accept_c      = tx_valid && ready_q;
        timer_clear_c = (state_q == ST_IDLE) || bit_end_c;
        two_bits_c    = (state_q == ST_STOP) && cfg_q.stop2;
    end

    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear_c),
        .two_bits (two_bits_c),
        .bit_end  (bit_end_c)
    );

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        data_hold_d = data_hold_q;
        cfg_d       = cfg_q;
        parity_d    = parity_q;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    data_hold_d = data_in;
                    cfg_d.ptype = parity_type;
                    cfg_d.stop2 = stop2;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
                        state_d = has_parity(cfg_q.ptype) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bit index restarts whenever the state changes.
        if (state_d != state_q) begin
            bit_d = '0;
        end

        // Parity bit is captured once, as the PARITY state is entered.
        if ((state_d == ST_PARITY) && (state_q != ST_PARITY)) begin
            parity_d = parity_in;
        end

        // Line level for the cycle that follows this edge.
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_hold_d[bit_d];
            ST_PARITY: tx_d = parity_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            data_hold_q <= '0;
            cfg_q       <= '0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            data_hold_q <= data_hold_d;
            cfg_q       <= cfg_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    // Output mapping.
    always_comb begin
        tx        = tx_q;
        busy      = busy_q;
        done      = done_q;
        tx_ready  = ready_q;
        data_hold = data_hold_q;
        type_hold = cfg_q.ptype;
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer at WIDTH=8, CLKS_PER_BIT=4.
module tb_tx_frame_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CPB   = 4;

    logic             clk;
    logic             rst;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       parity_type;
    logic             stop2;
    logic [WIDTH-1:0] data_hold;
    logic [1:0]       type_hold;
    logic             parity_in;
    logic             tx;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    tx_frame_serializer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .data_in     (data_in),
        .parity_type (parity_type),
        .stop2       (stop2),
        .data_hold   (data_hold),
        .type_hold   (type_hold),
        .parity_in   (parity_in),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external parity generator.
    always_comb begin
        if (type_hold == 2'b01)      parity_in = ~(^data_hold);
        else if (type_hold == 2'b10) parity_in = ^data_hold;
        else                         parity_in = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Accept one frame at the current cycle and follow it to its done cycle.
    // Returns at the done cycle's sample point, so a following call accepts back-to-back.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] pt, input logic s2,
                             input logic has_par, input logic ep, input int exp_busy,
                             input logic [7:0] next_d, input logic hold_valid);
        logic [13:0] fr;
        int n;
        int bit_idx;
        fr = has_par ? {4'b1111, ep, d, 1'b0} : {5'b11111, d, 1'b0};
        tx_valid    = 1'b1;
        data_in     = d;
        parity_type = pt;
        stop2       = s2;
        check("ready_before_accept", tx_ready, 1'b1);
        check("tx_idle_before_accept", tx, 1'b1);
        tick();
        if (!hold_valid) tx_valid = 1'b0;
        data_in     = next_d;
        parity_type = ~pt;
        stop2       = ~s2;
        check("busy_after_accept", busy, 1'b1);
        check("ready_low_in_frame", tx_ready, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            bit_idx = n / int'(CPB);
            if (bit_idx < 14) check("tx_bit", tx, fr[bit_idx]);
            check("done_low_in_frame", done, 1'b0);
            if (n == 20) check("data_hold_mid", data_hold, d);
            n++;
            tick();
        end
        check("busy_cycles", n, exp_busy);
        check("done_pulse", done, 1'b1);
        check("tx_high_done_cycle", tx, 1'b1);
        check("ready_done_cycle", tx_ready, 1'b1);
        check("data_hold_end", data_hold, d);
        check("type_hold_end", type_hold, pt);
    endtask

    initial begin
        rst         = 1'b1;
        tx_valid    = 1'b0;
        data_in     = 8'h00;
        parity_type = 2'b00;
        stop2       = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data_hold", data_hold, 8'h00);
        check("rst_type_hold", type_hold, 2'b00);
        rst = 1'b0;
        tick();
        check("rst_ready_after_release", tx_ready, 1'b1);
        tick();

        // 0xA5 odd parity, one stop: parity 1, 44 busy cycles; data_in toggled to 0xFF mid-frame.
        run_frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 44, 8'hFF, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("data_hold_after_done", data_hold, 8'hA5);
        tick();

        // 0xA5 even parity, two stops: parity 0, 48 busy cycles.
        run_frame(8'hA5, 2'b10, 1'b1, 1'b1, 1'b0, 48, 8'hFF, 1'b0);
        tick();
        tick();

        // 0x3C with type 11 and type 00: no parity bit, 40 busy cycles.
        run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 40, 8'h00, 1'b0);
        tick();
        check("type_hold_11_kept", type_hold, 2'b11);
        tick();
        run_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 40, 8'h00, 1'b0);
        tick();
        tick();

        // Back-to-back with tx_valid held: 0x80 accepted in the done cycle of 0x01.
        run_frame(8'h01, 2'b01, 1'b0, 1'b1, 1'b0, 44, 8'h80, 1'b1);
        run_frame(8'h80, 2'b01, 1'b0, 1'b1, 1'b0, 44, 8'h00, 1'b0);
        tick();
        check("b2b_idle_after", busy, 1'b0);
        tick();

        // Reset during DATA bit 3 of 0xA5, then a clean 0x55 frame.
        tx_valid    = 1'b1;
        data_in     = 8'hA5;
        parity_type = 2'b00;
        stop2       = 1'b0;
        tick();
        tx_valid = 1'b0;
        repeat (16) tick();
        check("abort_at_bit3", tx, 1'b0);
        check("abort_busy_before", busy, 1'b1);
        rst      = 1'b1;
        tx_valid = 1'b1;
        tick();
        rst      = 1'b0;
        tx_valid = 1'b0;
        check("abort_tx_high", tx, 1'b1);
        check("abort_busy_low", busy, 1'b0);
        check("abort_ready", tx_ready, 1'b1);
        check("abort_no_done", done, 1'b0);
        check("abort_data_hold_cleared", data_hold, 8'h00);
        tick();
        check("abort_no_done_later", done, 1'b0);
        check("abort_valid_ignored", busy, 1'b0);
        tick();
        run_frame(8'h55, 2'b10, 1'b0, 1'b1, 1'b0, 44, 8'hFF, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_serializer.md
TX_FRAME_SERIALIZER -- requirements
Module: tx_frame_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_valid  input  1  frame request qualifier.
REQ-006 SHALL have port tx_ready  output  1  high when a request can be accepted.
REQ-007 SHALL have port data_in  input  WIDTH  payload, sampled on accept.
REQ-008 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 no parity in frame; sampled on accept.
REQ-009 SHALL have port stop2  input  1  0 = one stop bit, 1 = two; sampled on accept.
REQ-010 SHALL have port data_hold  output  WIDTH  latched payload, drives the external parity generator.
REQ-011 SHALL have port type_hold  output  2  latched parity_type, drives the external parity generator.
REQ-012 SHALL have port parity_in  input  1  parity bit returned by the external parity generator.
REQ-013 SHALL have port tx  output  1  serial line, idle high.
REQ-014 SHALL have port busy  output  1  high while a frame is on the line.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL accept a frame on a cycle with tx_valid=1 and tx_ready=1; tx_ready=1 only in IDLE.
REQ-018 SHALL, on accept, latch data_in, parity_type, stop2 into data_hold, type_hold, stop register, and enter START next cycle.
REQ-019 SHALL hold tx=0 in START for CLKS_PER_BIT cycles, first START cycle being the cycle after accept.
REQ-020 SHALL send data_hold LSB first in DATA, each bit held CLKS_PER_BIT cycles, bit index 0..WIDTH-1.
REQ-021 SHALL enter PARITY after bit WIDTH-1 only when type_hold is 01 or 10; otherwise go directly to STOP.
REQ-022 SHALL drive tx=parity_in in PARITY for CLKS_PER_BIT cycles; parity_in sampled into a register on PARITY entry.
REQ-023 SHALL hold tx=1 in STOP for CLKS_PER_BIT (stop2=0) or 2*CLKS_PER_BIT (stop2=1) cycles.
REQ-024 SHALL return to IDLE after the last STOP cycle, asserting done=1 for exactly the first IDLE cycle.
REQ-025 SHALL allow a new accept in the done cycle; next START begins the following cycle (one idle-high cycle between frames).
REQ-026 SHALL ignore tx_valid and input changes while busy; data_hold and type_hold stable from accept until next accept.
REQ-027 SHALL keep busy=1 from START entry through last STOP cycle, 0 otherwise; tx=1 in IDLE.
REQ-028 SHALL size bit counter ceil(log2(WIDTH)) bits and baud counter ceil(log2(2*CLKS_PER_BIT)) bits; counters reset to 0 on every state change, no wrap past terminal value.
REQ-029 SHALL produce frame length 1+WIDTH+P+S bits, P in {0,1}, S in {1,2}, exactly CLKS_PER_BIT cycles each.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, set state IDLE, tx=1, tx_ready=1 after release, busy=0, done=0, counters 0, data_hold=0, type_hold=00.
REQ-031 SHALL abort any frame in progress on rst; tx returns high the cycle after the edge, no done pulse.
REQ-032 SHALL ignore tx_valid on cycles where rst=1.

Structure
REQ-033 SHALL take parity_type encodings and the state enumeration from shared package uart_pkg.
REQ-034 SHALL place the baud counter in sub-module tx_bit_timer (inputs clear, two_bits; output bit_end pulse).
REQ-035 SHALL keep parity computation external; connect data_hold/type_hold to the team parity generator and its output to parity_in.

Verification (CLKS_PER_BIT=4, WIDTH=8)
REQ-036 SHALL check 0xA5, type 01, stop2=0 -> tx: 0, 1,0,1,0,0,1,0,1, parity 1, stop 1; 44 busy cycles; done on cycle 45 after accept.
REQ-037 SHALL check 0xA5, type 10, stop2=1 -> parity bit 0, stop high 8 cycles, 48 busy cycles.
REQ-038 SHALL check 0x3C, type 11 and type 00 -> no parity bit, 40 busy cycles; type_hold=11 stays visible.
REQ-039 SHALL check back-to-back: tx_valid held high with 0x01 then 0x80 -> second accepted in done cycle, exactly one idle-high cycle between frames.
REQ-040 SHALL check rst asserted at DATA bit 3 -> tx=1, busy=0, tx_ready=1 next cycle, no done; following frame 0x55 correct.
REQ-041 SHALL check data_in changed to 0xFF mid-frame -> transmitted bits and data_hold unchanged.
